// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 8N1 framing at OVERS ticks per bit, with break rejection after a framing error.
// Build option MIDI_RX_MAJORITY_EN: decide each bit by a 2-of-3 vote of rxs around the sample point.
module midi_uart_rx #(
    parameter int OVERS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(OVERS);

    localparam logic [CW-1:0] CNT_MAX = CW'(OVERS - 1);
`ifdef MIDI_RX_MAJORITY_EN
    // The vote straddles mid-bit, so the decision falls one tick after the single-sample point.
    localparam logic [CW-1:0] START_PT = CW'(OVERS / 2);
`else
    localparam logic [CW-1:0] START_PT = CW'(OVERS / 2 - 1);
`endif
    localparam logic [CW-1:0] BIT_PT = CW'(OVERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    data_nxt;
    logic          valid_nxt, ferr_nxt;
    logic          sync1, rxs;
    logic [CW-1:0] pt;
    logic          bit_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    assign pt = (state == START) ? START_PT : BIT_PT;

`ifdef MIDI_RX_MAJORITY_EN
    logic vote0, vote1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote0 <= 1'b1;
            vote1 <= 1'b1;
        end else if (tick) begin
            if (cnt == pt - CW'(2)) vote0 <= rxs;
            if (cnt == pt - CW'(1)) vote1 <= rxs;
        end
    end

    assign bit_val = (vote0 & vote1) | (vote0 & rxs) | (vote1 & rxs);
`else
    assign bit_val = rxs;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_nxt = shift;
        idx_nxt   = idx;
        data_nxt  = data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        if (tick) begin
            cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (!rxs) state_nxt = START;
                end
                START: begin
                    if (cnt == pt) begin
                        state_nxt = bit_val ? IDLE : DATA;
                        idx_nxt   = 3'd0;
                    end
                end
                DATA: begin
                    if (cnt == pt) begin
                        shift_nxt = {bit_val, shift[7:1]};
                        if (idx == 3'd7) state_nxt = STOP;
                        else             idx_nxt   = idx + 3'd1;
                    end
                end
                STOP: begin
                    if (cnt == pt) begin
                        if (bit_val) begin
                            data_nxt  = shift;
                            valid_nxt = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must not restart reception until it returns high.
                    if (rxs) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
            if (state_nxt != state) cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= 8'h00;
            idx       <= 3'd0;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shift     <= shift_nxt;
            idx       <= idx_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            frame_err <= ferr_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/midi_uart_rx.md
MIDI_UART_RX -- requirements
Module: midi_uart_rx

Interface
REQ-001 SHALL have parameter OVERS, default 16: tick pulses per bit period; legal values are even numbers of at least 8.
REQ-002 SHALL have port clk  input  1  system clock (100 MHz); the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port tick  input  1  one-clk pulse at OVERS x 31250 Hz, from the baud tick generator.
REQ-005 SHALL have port rxd  input  1  asynchronous MIDI serial line, idle high.
REQ-006 SHALL have port data  output  8  last correctly framed byte.
REQ-007 SHALL have port valid  output  1  one-clk pulse: data was updated this cycle.
REQ-008 SHALL have port frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer; all later logic uses only the synchronized value rxs.
REQ-011 SHALL implement the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-012 SHALL have a tick counter sized to count 0..OVERS-1 that advances only on cycles with tick=1 and clears on every state change.
REQ-013 IDLE: when rxs is low on a tick cycle -> START with counter=0.
REQ-014 START: at tick count OVERS/2-1 (mid start bit), the sampled bit decides: low -> DATA (bit index 0); high -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: sample once every OVERS ticks, measured from the mid-start point; shift LSB first into an 8-bit shift register; after the 8th sample -> STOP.
REQ-016 STOP: sample after OVERS ticks. If high: data <= shift register, valid=1 for one clk, then IDLE. If low: frame_err=1 for one clk, data unchanged, then WAIT_IDLE.
REQ-017 WAIT_IDLE: stay until rxs is high on a tick cycle, then IDLE; this prevents a break condition from being received as 0x00 bytes.
REQ-018 Latency: valid asserts on the clk after the tick that samples mid stop bit; this is about 9.5 bit periods after the start-bit falling edge.
REQ-019 valid and frame_err SHALL never assert in the same cycle, and each SHALL be low in every other cycle.
REQ-020 Cycles with tick=0 SHALL not change state, counter or shift register.
REQ-021 Back-to-back bytes (next start edge directly after the stop bit) SHALL be received with no lost byte.

Reset
REQ-022 While rst_n is low: state=IDLE, counter=0, shift register=0x00, data=0x00, valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-023 rst_n asserted mid-frame SHALL abort the frame immediately with no pulse; after release, reception resumes at the next falling edge seen in IDLE.

Configuration
REQ-024 SHALL use the macro MIDI_RX_MAJORITY_EN.
REQ-025 With MIDI_RX_MAJORITY_EN defined: each start, data and stop bit value SHALL be the 2-of-3 majority of rxs taken at tick counts OVERS/2-2, OVERS/2-1 and OVERS/2 around the sample point; the decision is made at the third sample.
REQ-026 Without MIDI_RX_MAJORITY_EN: each bit value SHALL be a single rxs sample at the sample point; no extra registers are used.

Verification
REQ-027 SHALL have a bench at CLK_HZ=100e6 with a baud_gen tick (period 200 clk) and bit time 3200 clk; serial frame 0x90 -> valid exactly once, data=0x90, frame_err never asserts.
REQ-028 SHALL send the bytes 0x90, 0x3C, 0x7F back-to-back with no idle gap -> three valid pulses with data 0x90, 0x3C, 0x7F in that order.
REQ-029 SHALL apply a 1000-clk low glitch on an idle line -> no valid, no frame_err, busy returns low within 1 bit time.
REQ-030 SHALL send frame 0x55 with the stop bit forced low, then hold the line low for 5 bit times, then high -> exactly one frame_err, zero valid, data keeps its prior value; a following 0xF8 frame gives valid with data=0xF8.
REQ-031 SHALL pulse rst_n low for 10 clk during data bit 4 of a frame -> outputs reach reset values asynchronously, no pulse for the aborted frame, and the next 0x80 frame is received correctly.
REQ-032 With MIDI_RX_MAJORITY_EN defined: a 1-tick inverted glitch on rxd at the mid-point of bit 3 of frame 0xA5 -> data=0xA5; without the macro, the same glitch may corrupt bit 3.
